// File: rtl/optical_flow_grad_pkg.sv
// Shared types and clamp helpers for the optical-flow gradient block.
package optical_flow_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_CAP,
        S_WR_T,
        S_WR_X,
        S_DONE
    } flow_state_t;

    localparam logic MODE_T_ONLY = 1'b0;
    localparam logic MODE_T_X    = 1'b1;

    function automatic logic signed [63:0] out_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] out_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/optical_flow_grad_if.sv
// ap_ctrl_hs control plus img/prev read and flow write memory ports.
interface optical_flow_grad_if #(
    parameter int IMG_ADDR_W  = 10,
    parameter int FLOW_ADDR_W = 11,
    parameter int DATA_W      = 32
);
    logic                   ap_start;
    logic                   mode;
    logic                   ap_done;
    logic                   ap_idle;
    logic                   ap_ready;
    logic                   img_ce0;
    logic [IMG_ADDR_W-1:0]  img_address0;
    logic [DATA_W-1:0]      img_q0;
    logic                   prev_ce0;
    logic [IMG_ADDR_W-1:0]  prev_address0;
    logic [DATA_W-1:0]      prev_q0;
    logic                   flow_ce0;
    logic                   flow_we0;
    logic [FLOW_ADDR_W-1:0] flow_address0;
    logic [DATA_W-1:0]      flow_d0;

    // master is the kernel side: it issues memory requests and reports status
    modport master (
        input  ap_start, mode, img_q0, prev_q0,
        output ap_done, ap_idle, ap_ready,
               img_ce0, img_address0, prev_ce0, prev_address0,
               flow_ce0, flow_we0, flow_address0, flow_d0
    );

    modport slave (
        output ap_start, mode, img_q0, prev_q0,
        input  ap_done, ap_idle, ap_ready,
               img_ce0, img_address0, prev_ce0, prev_address0,
               flow_ce0, flow_we0, flow_address0, flow_d0
    );
endinterface

// File: rtl/optical_flow_grad_sat_diff.sv
// Unsigned pixel difference, signed clamp to OUT_W, sign-extended to DATA_W.
module sat_diff
    import optical_flow_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int OUT_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic [PIX_W-1:0]  a,
    input  logic [PIX_W-1:0]  b,
    output logic [DATA_W-1:0] y
);
    logic signed [PIX_W:0] d;
    logic signed [63:0]    dw;
    logic signed [63:0]    cl;

    assign d  = $signed({1'b0, a}) - $signed({1'b0, b});
    assign dw = {{(63 - PIX_W){d[PIX_W]}}, d};

    always_comb begin
        cl = dw;
        if (dw > out_max(OUT_W))
            cl = out_max(OUT_W);
        else if (dw < out_min(OUT_W))
            cl = out_min(OUT_W);
    end

    // low DATA_W bits of the wide clamped value are its sign extension
    assign y = DATA_W'(cl);
endmodule

// File: rtl/optical_flow_grad.sv
// Per-pixel temporal difference It and backward horizontal gradient Ix over one frame.
module optical_flow_grad
    import optical_flow_pkg::*;
#(
    parameter int IMG_W       = 32,
    parameter int IMG_H       = 32,
    parameter int DATA_W      = 32,
    parameter int PIX_W       = 8,
    parameter int OUT_W       = 16,
    parameter int RD_LAT      = 1,
    parameter int IMG_ADDR_W  = $clog2(IMG_W * IMG_H),
    parameter int FLOW_ADDR_W = IMG_ADDR_W + 1
) (
    input logic                clk,
    input logic                rst,
    optical_flow_grad_if.master bus
);
    localparam int N  = IMG_W * IMG_H;
    localparam int XW = $clog2(IMG_W);
    localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    flow_state_t           state, state_nxt;
    logic [IMG_ADDR_W-1:0] p;
    logic [XW-1:0]         x;
    logic                  mode_r;
    logic [PIX_W-1:0]      last;
    logic [DATA_W-1:0]     it_r, ix_r;
    logic [DATA_W-1:0]     it_w, ix_w;
    logic [WW-1:0]         wcnt;
    logic [PIX_W-1:0]      a_pix, b_pix, ix_ref;
    logic                  last_pix;
    logic                  advance;

    assign a_pix    = PIX_W'(bus.img_q0);
    assign b_pix    = PIX_W'(bus.prev_q0);
    // at the first column Ix is defined as 0, so subtract the pixel from itself
    assign ix_ref   = (x == '0) ? a_pix : last;
    assign last_pix = (p == IMG_ADDR_W'(N - 1));
    assign advance  = (state == S_WR_X) || (state == S_WR_T && mode_r == MODE_T_ONLY);

    sat_diff #(.PIX_W(PIX_W), .OUT_W(OUT_W), .DATA_W(DATA_W)) u_it (
        .a(a_pix), .b(b_pix), .y(it_w)
    );

    sat_diff #(.PIX_W(PIX_W), .OUT_W(OUT_W), .DATA_W(DATA_W)) u_ix (
        .a(a_pix), .b(ix_ref), .y(ix_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.ap_start) state_nxt = S_READ;
            S_READ: state_nxt = (RD_LAT > 1) ? S_WAIT : S_CAP;
            S_WAIT: if (wcnt == WW'(RD_LAT - 2)) state_nxt = S_CAP;
            S_CAP:  state_nxt = S_WR_T;
            S_WR_T: begin
                if (mode_r == MODE_T_X) state_nxt = S_WR_X;
                else                    state_nxt = last_pix ? S_DONE : S_READ;
            end
            S_WR_X: state_nxt = last_pix ? S_DONE : S_READ;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p      <= '0;
            x      <= '0;
            mode_r <= 1'b0;
            last   <= '0;
            it_r   <= '0;
            ix_r   <= '0;
            wcnt   <= '0;
        end else begin
            if (state == S_IDLE && bus.ap_start) begin
                mode_r <= bus.mode;
                p      <= '0;
                x      <= '0;
            end
            if (state == S_READ)
                wcnt <= '0;
            else if (state == S_WAIT)
                wcnt <= wcnt + 1'b1;
            if (state == S_CAP) begin
                it_r <= it_w;
                ix_r <= ix_w;
                last <= a_pix;
            end
            if (advance && !last_pix) begin
                p <= p + 1'b1;
                x <= (x == XW'(IMG_W - 1)) ? '0 : x + 1'b1;
            end
        end
    end

    // all outputs decode registered state only, so reset clears them immediately
    always_comb begin
        bus.ap_idle       = (state == S_IDLE);
        bus.ap_done       = (state == S_DONE);
        bus.ap_ready      = (state == S_DONE);
        bus.img_ce0       = 1'b0;
        bus.img_address0  = '0;
        bus.prev_ce0      = 1'b0;
        bus.prev_address0 = '0;
        bus.flow_ce0      = 1'b0;
        bus.flow_we0      = 1'b0;
        bus.flow_address0 = '0;
        bus.flow_d0       = '0;
        case (state)
            S_READ: begin
                bus.img_ce0       = 1'b1;
                bus.prev_ce0      = 1'b1;
                bus.img_address0  = p;
                bus.prev_address0 = p;
            end
            S_WR_T: begin
                bus.flow_ce0      = 1'b1;
                bus.flow_we0      = 1'b1;
                bus.flow_address0 = (mode_r == MODE_T_X) ? FLOW_ADDR_W'({p, 1'b0})
                                                         : FLOW_ADDR_W'(p);
                bus.flow_d0       = it_r;
            end
            S_WR_X: begin
                bus.flow_ce0      = 1'b1;
                bus.flow_we0      = 1'b1;
                bus.flow_address0 = FLOW_ADDR_W'({p, 1'b1});
                bus.flow_d0       = ix_r;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_optical_flow_grad.sv
// Randomized scoreboard bench for optical_flow_grad: frame model vs observed flow writes.
module tb_optical_flow_grad;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 2;
    localparam int N      = IMG_W * IMG_H;
    localparam int DW     = 32;
    localparam int PIX_W  = 8;
    localparam int OUT_W  = 5;
    localparam int RD_LAT = 3;
    localparam int AW     = $clog2(N);
    localparam int FW     = AW + 1;

    typedef struct {
        logic [FW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_done = 1'b0;

    wr_t  exp_q[$];
    int   done_q[$];

    logic [DW-1:0] img_mem [N];
    logic [DW-1:0] prev_mem[N];
    logic [DW-1:0] img_pipe [RD_LAT];
    logic [DW-1:0] prev_pipe[RD_LAT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    optical_flow_grad_if #(.IMG_ADDR_W(AW), .FLOW_ADDR_W(FW), .DATA_W(DW)) bus ();

    optical_flow_grad #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DW), .PIX_W(PIX_W), .OUT_W(OUT_W),
        .RD_LAT(RD_LAT), .IMG_ADDR_W(AW), .FLOW_ADDR_W(FW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // memories with RD_LAT-cycle read latency; garbage when not enabled
    always @(posedge clk) begin
        img_pipe[0]  <= bus.img_ce0  ? img_mem[bus.img_address0]   : DW'($urandom);
        prev_pipe[0] <= bus.prev_ce0 ? prev_mem[bus.prev_address0] : DW'($urandom);
        for (int i = 1; i < RD_LAT; i++) begin
            img_pipe[i]  <= img_pipe[i-1];
            prev_pipe[i] <= prev_pipe[i-1];
        end
    end
    assign bus.img_q0  = img_pipe[RD_LAT-1];
    assign bus.prev_q0 = prev_pipe[RD_LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clampi(input int v);
        int hi = (1 << (OUT_W - 1)) - 1;
        int lo = -(1 << (OUT_W - 1));
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    // reference: It = a - b, Ix = a - left neighbour (0 at column 0), both clamped
    task automatic push_frame(input logic m);
        for (int p = 0; p < N; p++) begin
            int a, b, it, ix;
            wr_t w;
            a  = int'(img_mem[p] % 256);
            b  = int'(prev_mem[p] % 256);
            it = clampi(a - b);
            ix = (p % IMG_W == 0) ? 0 : clampi(a - int'(img_mem[p-1] % 256));
            if (m) begin
                w.addr = FW'(2 * p);     w.data = DW'(it); exp_q.push_back(w);
                w.addr = FW'(2 * p + 1); w.data = DW'(ix); exp_q.push_back(w);
            end else begin
                w.addr = FW'(p);         w.data = DW'(it); exp_q.push_back(w);
            end
        end
    endtask

    // monitor: pops expected writes and done times whenever the DUT presents them
    always @(negedge clk) begin
        if (rst) begin
            chk("writes_in_reset", {bus.flow_ce0, bus.flow_we0}, 0);
        end else begin
            if (bus.flow_we0) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr %0d data %0h, none expected", bus.flow_address0, bus.flow_d0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("flow_address0", bus.flow_address0, e.addr);
                    chk("flow_d0", bus.flow_d0, e.data);
                    chk("flow_ce0", bus.flow_ce0, 1);
                end
            end
            if (prev_done) chk("idle_after_done", bus.ap_idle, 1);
            if (bus.ap_done) begin
                chk("ap_ready_with_done", bus.ap_ready, 1);
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: at cycle %0d, none expected", cyc);
                end else begin
                    chk("done_cycle", cyc, done_q.pop_front());
                end
            end
        end
        prev_done <= bus.ap_done && !rst;
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ap_idle"}, bus.ap_idle, 1);
        chk({tag, "_done_ready"}, {bus.ap_done, bus.ap_ready}, 0);
        chk({tag, "_rd_en"}, {bus.img_ce0, bus.prev_ce0}, 0);
        chk({tag, "_rd_addr"}, {bus.img_address0, bus.prev_address0}, 0);
        chk({tag, "_flow"}, {bus.flow_ce0, bus.flow_we0, bus.flow_address0, bus.flow_d0}, 0);
    endtask

    task automatic run_frame(input logic m);
        bit got = 0;
        @(posedge clk); #1;
        bus.ap_start = 1'b1;
        bus.mode     = m;
        push_frame(m);
        done_q.push_back(cyc + 1 + N * (RD_LAT + 2 + int'(m)));
        for (int t = 0; t < 400 && !got; t++) begin
            @(posedge clk); #1;
            if (bus.ap_done) begin
                got = 1;
                // start held through DONE must not launch another frame
                bus.ap_start = 1'b1;
                @(posedge clk); #1;
                bus.ap_start = 1'b0;
            end else begin
                bus.ap_start = 1'($urandom);
                bus.mode     = 1'($urandom);
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL frame_timeout: mode %0d no ap_done", m);
            bus.ap_start = 1'b0;
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            img_mem[i]  = $urandom;
            prev_mem[i] = $urandom;
        end
    endtask

    initial begin
        bit hit = 0;
        bus.ap_start = 1'b0;
        bus.mode     = 1'b0;
        #1;
        check_reset_outputs("por");

        img_mem  = '{10, 20, 5, 5, 200, 0, 9, 2};
        prev_mem = '{10, 15, 8, 5, 3, 255, 0, 0};
        for (int i = 0; i < N; i++) begin
            img_mem[i][DW-1:PIX_W]  = (DW - PIX_W)'($urandom);
            prev_mem[i][DW-1:PIX_W] = (DW - PIX_W)'($urandom);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        run_frame(1'b0);
        run_frame(1'b1);
        for (int k = 0; k < 6; k++) begin
            fill_random();
            run_frame(1'($urandom));
        end

        // reset while pixel 2 is being written
        fill_random();
        @(posedge clk); #1;
        bus.ap_start = 1'b1;
        bus.mode     = 1'b0;
        push_frame(1'b0);
        @(posedge clk); #1;
        bus.ap_start = 1'b0;
        for (int t = 0; t < 200 && !hit; t++) begin
            @(posedge clk); #3;
            if (bus.flow_we0 && bus.flow_address0 == FW'(2)) hit = 1;
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL reset_target: WR_T of pixel 2 not reached");
        end
        rst = 1'b1;
        exp_q.delete();
        done_q.delete();
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        fill_random();
        run_frame(1'b0);
        run_frame(1'b1);

        repeat (5) @(posedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/optical_flow_grad.md
Name: optical_flow_grad

Overview:
- Native-RTL, parametrised successor to the HLS optical-flow kernel. It keeps the same ap_ctrl_hs handshake and single-port memory interfaces (img, prev read; flow write).
- Per pixel it computes the temporal difference It = img - prev and the backward horizontal gradient Ix = img[x] - img[x-1].
- Frame size, pixel width, memory read latency and output clamp are parameters.
- A run-time mode selects It-only output or interleaved It/Ix output.
- Sits between the frame buffers and the flow-vector consumer in the optical_flow benchmark.

Parameters:
- IMG_W, 32: pixels per row (>=2).
- IMG_H, 32: rows per frame (>=1).
- DATA_W, 32: memory word width.
- PIX_W, 8: unsigned pixel bits, taken from the low bits of img_q0/prev_q0. PIX_W < DATA_W.
- OUT_W, 16: signed clamp width of each result. 2 <= OUT_W <= DATA_W.
- RD_LAT, 1: memory read latency in cycles (>=1).
- IMG_ADDR_W, $clog2(IMG_W*IMG_H): img/prev address width.
- FLOW_ADDR_W, IMG_ADDR_W+1: flow address width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ap_start  in  1  start request.
- mode  in  1  0 = It only, 1 = It and Ix interleaved. Latched when start is accepted.
- ap_done  out  1  one-cycle pulse when the frame completes.
- ap_idle  out  1  high while in IDLE.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done.
- img_ce0  out  1  img read enable.
- img_address0  out  IMG_ADDR_W  img read address.
- img_q0  in  DATA_W  img read data.
- prev_ce0  out  1  prev read enable.
- prev_address0  out  IMG_ADDR_W  prev read address.
- prev_q0  in  DATA_W  prev read data.
- flow_ce0  out  1  flow enable.
- flow_we0  out  1  flow write enable.
- flow_address0  out  FLOW_ADDR_W  flow address.
- flow_d0  out  DATA_W  flow write data.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - State goes to IDLE; pixel index p, column x and registers clear.
  - All outputs are 0 except ap_idle = 1.
  - No partial writes complete after reset asserts.
- Signal decoding:
  - ap_idle is high exactly when the state is IDLE.
  - ap_done and ap_ready are high exactly in DONE.
  - All memory enables and addresses are registered-state decodes, 0 outside the states listed below.
- States: IDLE, READ, WAIT, CAP, WR_T, WR_X, DONE.
- IDLE:
  - When ap_start = 1: latch mode, p = 0, x = 0, go to READ.
  - When ap_start = 0: stay in IDLE.
- READ:
  - img_ce0 = prev_ce0 = 1; img_address0 = prev_address0 = p.
  - Go to WAIT if RD_LAT > 1, else go to CAP.
- WAIT: hold for RD_LAT-1 cycles, enables 0.
- CAP (exactly RD_LAT cycles after READ):
  - Sample the low PIX_W bits of img_q0 and prev_q0 as unsigned values a and b.
  - It = a - b, computed in PIX_W+1-bit signed.
  - Ix = a - last, where last is a held from the previous pixel. Ix = 0 when x = 0.
  - Both results are clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1], then sign-extended to DATA_W.
  - Register It, Ix; set last = a.
- WR_T:
  - flow_ce0 = flow_we0 = 1; flow_d0 = It.
  - flow_address0 = p in mode 0, 2p in mode 1.
  - Go to WR_X if mode = 1, else advance.
- WR_X: flow_ce0 = flow_we0 = 1, flow_address0 = 2p+1, flow_d0 = Ix, then advance.
- Advance:
  - If p = IMG_W*IMG_H-1, go to DONE.
  - Otherwise p++, x++ (x wraps to 0 at IMG_W, so Ix restarts each row), go to READ.
- DONE: single cycle, then IDLE. ap_start high in DONE is ignored; a new start needs ap_start in IDLE.
- ap_start and mode changes while busy are ignored.
- Timing:
  - Per-pixel cycles: RD_LAT+2 in mode 0, RD_LAT+3 in mode 1.
  - Latency from the start-accept edge to ap_done high = N*(per-pixel cycles), where N = IMG_W*IMG_H.
  - ap_done lasts 1 cycle.
- In mode 0, flow addresses >= N are never written.

Decomposition:
- Package optical_flow_pkg:
  - state enum flow_state_t.
  - MODE_T_ONLY = 1'b0, MODE_T_X = 1'b1.
  - clamp helper constants (OUT_MAX, OUT_MIN as functions of OUT_W).
- Sub-module sat_diff: combinational unsigned PIX_W subtract, signed clamp to OUT_W, sign-extend to DATA_W. Instantiated twice (It, Ix).

Test Plan:
- Params IMG_W=4, IMG_H=1, RD_LAT=1, mode 0; img = 10, 20, 5, 5; prev = 10, 15, 8, 5.
  - Required: flow[0..3] = 0, 5, -3, 0.
  - ap_done exactly 12 cycles after the start-accept edge; ap_idle high again the next cycle.
- Same data, mode 1.
  - Required: flow[0..7] = 0, 0, 5, 10, -3, -15, 0, 0.
  - 16 cycles to ap_done; addresses seen in order 0..7.
- IMG_W=2, IMG_H=2, mode 1; img = 1, 4, 9, 2; prev = 0.
  - Required: Ix at x=0 of row 1 is 0 (flow[5] = 0), and flow[7] = -7.
- OUT_W=4, PIX_W=8; img = 200, prev = 3.
  - Required: It clamped to 7 (flow_d0 = 32'h00000007).
  - img = 0, prev = 255: It = -8 (32'hFFFFFFF8).
- RD_LAT=3, mode 0, 4 pixels.
  - Required: reads sampled 3 cycles after each READ; 20 cycles to ap_done.
  - ap_start held high and mode toggled mid-frame have no effect.
- Assert rst during the WR_T of pixel 2.
  - Required: all outputs 0 (ap_idle = 1) asynchronously, with no further flow writes.
  - The next ap_start restarts from address 0.
